// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed seven-segment bus: waits for each anode/segment pair
// to settle, decodes it back to a hex nibble and rebuilds the full multi-digit value.
module seg_scan_capture #(
  parameter int N_DIGITS   = 8,
  parameter int SETTLE     = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   an_in,
  input  logic [6:0]            seg_in,
  output logic [4*N_DIGITS-1:0] digits_out,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  frame_done,
  output logic                  pattern_err,
  output logic                  anode_err
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(SETTLE);
  localparam logic [SW-1:0] STAB_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {S_WAIT, S_SETTLING, S_SAMPLE, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [SW-1:0]         stab_q, stab_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d;
  logic [N_DIGITS-1:0]   mask_q, mask_d;
  logic                  frame_q, frame_d;
  logic                  perr_q, perr_d;
  logic                  aerr_q, aerr_d;
  logic                  chg;
  logic [4:0]            dec;

  // Returns {hit, nibble}; 7 and 9 each accept two common segment renderings.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h00;
    case (seg)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07, 7'h27: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F, 7'h67: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    an_d  = ACTIVE_LOW ? ~an_in : an_in;
    seg_d = ACTIVE_LOW ? ~seg_in : seg_in;
    chg   = ({an_d, seg_d} != {an_q, seg_q});
    if (chg)
      stab_d = '0;
    else if (stab_q == STAB_MAX)
      stab_d = stab_q;
    else
      stab_d = stab_q + 1'b1;

    // A fresh pair can only reach SAMPLE directly from a change when SETTLE is 1.
    state_d = S_WAIT;
    if (an_d == '0)
      state_d = S_WAIT;
    else if (chg)
      state_d = (stab_d == STAB_LAST) ? S_SAMPLE : S_WAIT;
    else if (state_q == S_SAMPLE || state_q == S_HOLD)
      state_d = S_HOLD;
    else if (stab_d == STAB_LAST)
      state_d = S_SAMPLE;
    else
      state_d = S_SETTLING;
  end

  always_comb begin
    dec      = decode(seg_q);
    digits_d = digits_q;
    valid_d  = valid_q;
    mask_d   = (&mask_q) ? '0 : mask_q;
    frame_d  = &mask_q;
    perr_d   = 1'b0;
    aerr_d   = 1'b0;
    if (state_q == S_SAMPLE) begin
      if ($onehot(an_q)) begin
        if (dec[4]) begin
          for (int i = 0; i < N_DIGITS; i++) begin
            if (an_q[i]) begin
              digits_d[4*i +: 4] = dec[3:0];
              valid_d[i]         = 1'b1;
              mask_d[i]          = 1'b1;
            end
          end
        end else begin
          perr_d = 1'b1;
        end
      end else begin
        aerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      an_q     <= '0;
      seg_q    <= '0;
      stab_q   <= '0;
      state_q  <= S_WAIT;
      digits_q <= '0;
      valid_q  <= '0;
      mask_q   <= '0;
      frame_q  <= 1'b0;
      perr_q   <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      an_q     <= an_d;
      seg_q    <= seg_d;
      stab_q   <= stab_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      frame_q  <= frame_d;
      perr_q   <= perr_d;
      aerr_q   <= aerr_d;
    end
  end

  assign digits_out  = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign pattern_err = perr_q;
  assign anode_err   = aerr_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: the driver predicts captures, frames and error
// pulses with their due cycle; a negedge monitor pops and compares them as they appear.
module tb_seg_scan_capture;

  localparam int SETTLE = 4;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int          kind;
    int          due;
    logic [31:0] digits;
    logic [7:0]  valid;
  } evt_t;

  logic        ck = 1'b0;
  logic        rst;
  logic [7:0]  an_in;
  logic [6:0]  seg_in;
  logic [31:0] digits_out;
  logic [7:0]  digit_valid;
  logic        frame_done, pattern_err, anode_err;

  evt_t        sb[$];
  int          cyc = 0;
  int          checkCount = 0;
  int          passCount = 0;
  bit          monitorEn = 1'b0;
  logic [39:0] last;
  logic [31:0] mDigits;
  logic [7:0]  mValid, mMask;

  seg_scan_capture #(.N_DIGITS(8), .SETTLE(SETTLE), .ACTIVE_LOW(1'b1)) dut (
    .ck(ck), .rst(rst), .an_in(an_in), .seg_in(seg_in),
    .digits_out(digits_out), .digit_valid(digit_valid),
    .frame_done(frame_done), .pattern_err(pattern_err), .anode_err(anode_err));

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [4:0] expectNibble(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h00;
    for (int i = 0; i < 16; i++)
      if (SEG_TABLE[i] == seg) r = {1'b1, 4'(i)};
    if (seg == 7'h27) r = 5'h17;
    if (seg == 7'h67) r = 5'h19;
    return r;
  endfunction

  task automatic pushEvt(input int kind, input int due);
    evt_t e;
    e.kind = kind; e.due = due; e.digits = mDigits; e.valid = mValid;
    sb.push_back(e);
  endtask

  task automatic handleEvent(input int kind);
    evt_t e;
    if (sb.size() == 0) begin
      checkOutput($sformatf("sb_unexpected_k%0d", kind), sb.size(), 1);
    end else begin
      e = sb.pop_front();
      checkOutput("ev_kind", kind, e.kind);
      checkOutput("ev_cycle", cyc, e.due);
      if (kind == 0) begin
        checkOutput("ev_digits", digits_out, e.digits);
        checkOutput("ev_valid", digit_valid, e.valid);
      end
    end
  endtask

  // Monitor: kind 0 capture (visible change), 1 frame, 2 pattern error, 3 anode error.
  always @(negedge ck) begin
    if (monitorEn) begin
      if ({digits_out, digit_valid} !== last) handleEvent(0);
      if (frame_done)  handleEvent(1);
      if (pattern_err) handleEvent(2);
      if (anode_err)   handleEvent(3);
    end
    last = {digits_out, digit_valid};
  end

  // Drives an active-high pair for n cycles followed by one blank cycle.
  task automatic applyStimulus(input logic [7:0] an, input logic [6:0] seg, input int n);
    logic [4:0]  dec;
    logic [31:0] nd;
    logic [7:0]  nv;
    int          k;
    an_in  = ~an;
    seg_in = ~seg;
    if (n >= SETTLE && an != 8'h00) begin
      if ($onehot(an)) begin
        dec = expectNibble(seg);
        if (dec[4]) begin
          k = 0;
          for (int i = 0; i < 8; i++) if (an[i]) k = i;
          nd = mDigits;
          nd[4*k +: 4] = dec[3:0];
          nv = mValid | an;
          if (nd != mDigits || nv != mValid) begin
            mDigits = nd; mValid = nv;
            pushEvt(0, cyc + 1 + SETTLE);
          end
          mMask = mMask | an;
          if (mMask == 8'hFF) begin
            pushEvt(1, cyc + 2 + SETTLE);
            mMask = 8'h00;
          end
        end else begin
          pushEvt(2, cyc + 1 + SETTLE);
        end
      end else begin
        pushEvt(3, cyc + 1 + SETTLE);
      end
    end
    repeat (n) @(negedge ck);
    an_in  = 8'hFF;
    seg_in = 7'h7F;
    @(negedge ck);
  endtask

  task automatic scanValue(input logic [31:0] v, input int firstDigit, input int lastDigit);
    logic [3:0] nib;
    for (int k = firstDigit; k <= lastDigit; k++) begin
      nib = v[4*k +: 4];
      applyStimulus(8'(1 << k), SEG_TABLE[nib], 6);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge ck);
    repeat (3) @(negedge ck);
    checkOutput("sb_drain", sb.size(), 0);
  endtask

  task automatic resetDut();
    monitorEn = 1'b0;
    an_in  = 8'hFF;
    seg_in = 7'h7F;
    rst    = 1'b1;
    repeat (3) @(negedge ck);
    checkOutput("rst_digits", digits_out, 0);
    checkOutput("rst_valid", digit_valid, 0);
    checkOutput("rst_frame", frame_done, 0);
    checkOutput("rst_perr", pattern_err, 0);
    checkOutput("rst_aerr", anode_err, 0);
    rst = 1'b0;
    mDigits = '0; mValid = '0; mMask = '0;
    sb.delete();
    @(negedge ck);
    monitorEn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    resetDut();

    scanValue(32'hE5D00814, 0, 7);
    scanValue(32'hE5D00814, 0, 7);
    drain();
    checkOutput("loop_digits", digits_out, 32'hE5D00814);
    checkOutput("loop_valid", digit_valid, 8'hFF);

    applyStimulus(8'h08, 7'h06, SETTLE - 1);
    drain();
    checkOutput("short_hold_d3", digits_out[15:12], 4'h0);
    applyStimulus(8'h08, 7'h06, SETTLE);
    drain();
    checkOutput("settle_hold_d3", digits_out[15:12], 4'h1);

    applyStimulus(8'h20, 7'h7E, 6);
    drain();
    checkOutput("perr_digits", digits_out, 32'hE5D01814);
    checkOutput("perr_valid", digit_valid, 8'hFF);

    applyStimulus(8'h12, 7'h3F, 6);
    applyStimulus(8'h00, 7'h3F, 100);
    drain();
    checkOutput("aerr_digits", digits_out, 32'hE5D01814);

    for (int r = 0; r < 3; r++) begin
      applyStimulus(8'h01, 7'h27, 5);
      applyStimulus(8'h02, 7'h67, 5);
    end
    drain();
    checkOutput("alt_7_9", digits_out[7:0], 8'h97);

    resetDut();
    scanValue(32'h12345678, 0, 4);
    drain();
    resetDut();
    scanValue(32'h12345678, 0, 7);
    drain();
    checkOutput("rescan_digits", digits_out, 32'h12345678);
    checkOutput("rescan_valid", digit_valid, 8'hFF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
